// File: rtl/prbs5_pkg.sv
// rtl/prbs5_pkg.sv - PRBS-5 constants, checker state encoding and tap predictor
package prbs5_pkg;

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int PRBS5_TAP_A = 1;
  localparam int PRBS5_TAP_B = 4;

  localparam logic [4:0] PRBS5_SEED = 5'b11111;

  typedef enum logic [1:0] {
    S_SEED   = ST_SEED,
    S_VERIFY = ST_VERIFY,
    S_LOCKED = ST_LOCKED
  } state_e;

  // hist[0] is the newest bit, so b[n] = b[n-2] ^ b[n-5] reads taps 1 and 4.
  function automatic logic prbs5_pred(input logic [4:0] hist);
    return hist[PRBS5_TAP_A] ^ hist[PRBS5_TAP_B];
  endfunction

endpackage

// File: rtl/prbs5_checker_if.sv
// rtl/prbs5_checker_if.sv - serial link input and status outputs of the PRBS-5 checker
interface prbs5_checker_if #(
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic             in_bit;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic             lock_lost;

  modport master (
    output in_valid,
    output in_bit,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  lock_lost
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    output locked,
    output err_pulse,
    output err_count,
    output lock_lost
  );

endinterface

// File: rtl/prbs_err_window.sv
// rtl/prbs_err_window.sv - error-density window; flags loss when LOSS_THR errors land in WIN_LEN bits
module prbs_err_window #(
  parameter int WIN_LEN  = 31,
  parameter int LOSS_THR = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic err,
  input  logic clear,
  output logic loss
);

  localparam int PW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int EW = $clog2(LOSS_THR + 1);

  logic [PW-1:0] win_pos_q, win_pos_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic [EW-1:0] err_sum;

  // win_err_q never holds LOSS_THR, so the sum always fits in EW bits.
  assign err_sum = win_err_q + EW'(err);
  assign loss    = advance && !clear && (err_sum >= EW'(LOSS_THR));

  always_comb begin
    win_pos_d = win_pos_q;
    win_err_d = win_err_q;
    if (clear) begin
      win_pos_d = '0;
      win_err_d = '0;
    end else if (advance) begin
      if (loss || (win_pos_q == PW'(WIN_LEN - 1))) begin
        win_pos_d = '0;
        win_err_d = '0;
      end else begin
        win_pos_d = win_pos_q + PW'(1);
        win_err_d = err_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_pos_q <= '0;
      win_err_q <= '0;
    end else begin
      win_pos_q <= win_pos_d;
      win_err_q <= win_err_d;
    end
  end

endmodule

// File: rtl/prbs5_checker.sv
// rtl/prbs5_checker.sv - self-synchronising PRBS-5 receiver with flywheel lock and error counting
module prbs5_checker
  import prbs5_pkg::*;
#(
  parameter int LOCK_CNT = 31,
  parameter int WIN_LEN  = 31,
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  prbs5_checker_if.slave       link
);

  state_e           state_q;
  logic [4:0]       hist_q, hist_d;
  logic [2:0]       seed_cnt_q;
  logic [7:0]       match_cnt_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic             lock_lost_q;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic pred;
  logic mismatch;
  logic win_advance;
  logic win_clear;
  logic win_loss;

  assign pred     = prbs5_pred(hist_q);
  assign mismatch = link.in_bit != pred;

  // While locked the history flywheels on its own prediction, so a corrupted
  // bit is counted once instead of poisoning the next five predictions.
  assign hist_d = {hist_q[3:0], (state_q == S_LOCKED) ? pred : link.in_bit};

  assign err_count_d = (err_count_q == {CNT_W{1'b1}}) ? err_count_q
                                                      : err_count_q + CNT_W'(1);

  assign win_advance = link.in_valid && (state_q == S_LOCKED);
  assign win_clear   = state_q != S_LOCKED;

  prbs_err_window #(
    .WIN_LEN  (WIN_LEN),
    .LOSS_THR (LOSS_THR)
  ) u_err_window (
    .clk     (clk),
    .rst     (rst),
    .advance (win_advance),
    .err     (mismatch),
    .clear   (win_clear),
    .loss    (win_loss)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SEED;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      if (link.in_valid) begin
        hist_q <= hist_d;
        unique case (state_q)
          S_SEED: begin
            if (seed_cnt_q == 3'd4) begin
              seed_cnt_q <= '0;
              // An all-zero seed is the LFSR lock-up state; keep collecting.
              if (hist_d != 5'd0) begin
                state_q     <= S_VERIFY;
                match_cnt_q <= '0;
              end
            end else begin
              seed_cnt_q <= seed_cnt_q + 3'd1;
            end
          end
          S_VERIFY: begin
            if (!mismatch) begin
              if (match_cnt_q == 8'(LOCK_CNT - 1)) begin
                state_q  <= S_LOCKED;
                locked_q <= 1'b1;
              end else begin
                match_cnt_q <= match_cnt_q + 8'd1;
              end
            end else begin
              state_q    <= S_SEED;
              seed_cnt_q <= 3'd1;
            end
          end
          S_LOCKED: begin
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
            end
            if (win_loss) begin
              state_q     <= S_SEED;
              seed_cnt_q  <= '0;
              locked_q    <= 1'b0;
              lock_lost_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= S_SEED;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign link.locked    = locked_q;
  assign link.err_pulse = err_pulse_q;
  assign link.err_count = err_count_q;
  assign link.lock_lost = lock_lost_q;

endmodule
